// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator.
//   csa_state_e   : control states (ACCUM, RESOLVE, OUTPUT)
//   csa_acc_width : accumulator width able to hold max_ops operands of width bits
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } csa_state_e;

    function automatic int unsigned csa_acc_width(input int unsigned width,
                                                  input int unsigned max_ops);
        return width + $clog2(max_ops);
    endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational 3:2 compressor row.
//   a, b, c : W-bit inputs
//   sum     : bitwise a ^ b ^ c
//   carry   : bitwise majority(a, b, c), unshifted (the parent shifts/truncates)
module csa_row #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator. Operands are folded into a redundant
// sum/carry pair; one carry-propagate add resolves the pair per frame.
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready/in_data/in_last : operand stream, in_last closes a frame
//   out_valid/out_ready            : result handshake
//   out_sum                        : frame sum modulo 2^ACC_W
//   out_count                      : operands in the frame
//   out_overflow                   : frame force-closed at MAX_OPS without in_last
module csa_accumulator
    import csa_pkg::*;
#(
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned MAX_OPS = 16,
    parameter  int unsigned SIGNED  = 0,
    localparam int unsigned ACC_W   = csa_acc_width(WIDTH, MAX_OPS),
    localparam int unsigned CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    localparam int unsigned EXT = ACC_W - WIDTH;

    csa_state_e       state, state_nxt;
    logic [ACC_W-1:0] sum_r, carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] row_sum, row_carry;
    logic             accept, close;

    always_comb begin
        if (SIGNED != 0) x = {{EXT{in_data[WIDTH-1]}}, in_data};
        else             x = {{EXT{1'b0}}, in_data};
    end

    csa_row #(.W(ACC_W)) u_row (
        .a     (sum_r),
        .b     (carry_r),
        .c     (x),
        .sum   (row_sum),
        .carry (row_carry)
    );

    assign accept = in_valid && in_ready;
    // cnt_r + 1 == MAX_OPS, expressed without widening cnt_r
    assign close  = in_last || (cnt_r == CNT_W'(MAX_OPS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && close) state_nxt = RESOLVE;
            RESOLVE: state_nxt = OUTPUT;
            OUTPUT:  if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == OUTPUT);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r        <= '0;
            carry_r      <= '0;
            cnt_r        <= '0;
            ovf_r        <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        sum_r   <= row_sum;
                        // carry weight doubles; the bit shifted past ACC_W is dropped
                        carry_r <= ACC_W'({row_carry, 1'b0});
                        cnt_r   <= cnt_r + CNT_W'(1);
                        if (close) ovf_r <= !in_last;
                    end
                end
                RESOLVE: begin
                    out_sum      <= sum_r + carry_r;
                    out_count    <= cnt_r;
                    out_overflow <= ovf_r;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        sum_r   <= '0;
                        carry_r <= '0;
                        cnt_r   <= '0;
                        ovf_r   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        u_in_ready, u_out_valid, u_out_overflow;
    logic [11:0] u_out_sum;
    logic [4:0]  u_out_count;
    logic        s_in_ready, s_out_valid, s_out_overflow;
    logic [11:0] s_out_sum;
    logic [4:0]  s_out_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csa_accumulator #(.WIDTH(8), .MAX_OPS(16), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u_out_valid),
        .out_ready(out_ready), .out_sum(u_out_sum), .out_count(u_out_count),
        .out_overflow(u_out_overflow)
    );

    csa_accumulator #(.WIDTH(8), .MAX_OPS(16), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_sum(s_out_sum), .out_count(s_out_count),
        .out_overflow(s_out_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operand and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!u_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!u_in_ready) check_eq("send_timeout", 32'(u_in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) at negedges until out_valid is seen.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!u_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!u_out_valid) check_eq({tag, "_valid_timeout"}, 32'(u_out_valid), 32'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1;
        // Reset state
        check_eq("rst_in_ready",  32'(u_in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(u_out_valid), 32'd0);
        check_eq("rst_out_sum",   32'(u_out_sum), 32'd0);
        check_eq("rst_out_count", 32'(u_out_count), 32'd0);
        check_eq("rst_out_ovf",   32'(u_out_overflow), 32'd0);
        #20 rst_n = 1'b1;

        // out_ready while idle has no effect
        handshake();
        @(negedge clk);
        check_eq("idle_oready_in_ready", 32'(u_in_ready), 32'd1);
        check_eq("idle_oready_valid",    32'(u_out_valid), 32'd0);

        // 3 + 5 + 7, exact latency
        send(8'd3, 1'b0);
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        @(negedge clk);
        check_eq("t1_resolve_valid", 32'(u_out_valid), 32'd0);
        check_eq("t1_resolve_ready", 32'(u_in_ready), 32'd0);
        @(negedge clk);
        check_eq("t1_valid", 32'(u_out_valid), 32'd1);
        check_eq("t1_sum",   32'(u_out_sum), 32'd15);
        check_eq("t1_count", 32'(u_out_count), 32'd3);
        check_eq("t1_ovf",   32'(u_out_overflow), 32'd0);
        handshake();
        check_eq("t1_ready_after_hs", 32'(u_in_ready), 32'd1);
        check_eq("t1_valid_after_hs", 32'(u_out_valid), 32'd0);

        // Sixteen x 0xFF with in_last on the 16th
        for (int i = 0; i < 16; i++) send(8'hFF, (i == 15));
        wait_valid("t2");
        check_eq("t2_sum",   32'(u_out_sum), 32'hFF0);
        check_eq("t2_count", 32'(u_out_count), 32'd16);
        check_eq("t2_ovf",   32'(u_out_overflow), 32'd0);
        handshake();

        // Seventeen x 1, forced close at 16; 17th stalls then opens next frame
        for (int i = 0; i < 16; i++) send(8'd1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd1;
        in_last  = 1'b1;
        check_eq("t3_stall_ready", 32'(u_in_ready), 32'd0);
        @(negedge clk);
        check_eq("t3_valid", 32'(u_out_valid), 32'd1);
        check_eq("t3_sum",   32'(u_out_sum), 32'd16);
        check_eq("t3_count", 32'(u_out_count), 32'd16);
        check_eq("t3_ovf",   32'(u_out_overflow), 32'd1);
        // Backpressure: five cycles with out_ready low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_sum",   32'(u_out_sum), 32'd16);
            check_eq("bp_ready", 32'(u_in_ready), 32'd0);
            check_eq("bp_valid", 32'(u_out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("t3_ready_after_hs", 32'(u_in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check_eq("t3b_resolve_ready", 32'(u_in_ready), 32'd0);
        @(negedge clk);
        check_eq("t3b_valid", 32'(u_out_valid), 32'd1);
        check_eq("t3b_sum",   32'(u_out_sum), 32'd1);
        check_eq("t3b_count", 32'(u_out_count), 32'd1);
        check_eq("t3b_ovf",   32'(u_out_overflow), 32'd0);
        handshake();

        // Signed vs unsigned: 0xFF, 0x80, 0x7F
        send(8'hFF, 1'b0);
        send(8'h80, 1'b0);
        send(8'h7F, 1'b1);
        wait_valid("t4");
        check_eq("t4_s_valid", 32'(s_out_valid), 32'd1);
        check_eq("t4_s_sum",   32'(s_out_sum), 32'hFFE);
        check_eq("t4_s_count", 32'(s_out_count), 32'd3);
        check_eq("t4_u_sum",   32'(u_out_sum), 32'h1FE);
        handshake();

        // Reset mid-frame
        send(8'd4, 1'b0);
        send(8'd6, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", 32'(u_in_ready), 32'd1);
        check_eq("mid_rst_valid",    32'(u_out_valid), 32'd0);
        check_eq("mid_rst_sum",      32'(u_out_sum), 32'd0);
        check_eq("mid_rst_s_sum",    32'(s_out_sum), 32'd0);
        check_eq("mid_rst_count",    32'(u_out_count), 32'd0);
        check_eq("mid_rst_ovf",      32'(u_out_overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd9, 1'b1);
        wait_valid("t5");
        check_eq("t5_sum",   32'(u_out_sum), 32'd9);
        check_eq("t5_count", 32'(u_out_count), 32'd1);
        check_eq("t5_ovf",   32'(u_out_overflow), 32'd0);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
